// File: rtl/mem_pkg.sv
// Shared definitions for the byte-copy DMA engine and its memory environment.
package mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } dma_state_t;

endpackage : mem_pkg

// File: rtl/mem_copy_dma.sv
// Byte-copy engine that owns the single port of the data memory.
// When idle, the CPU port is passed straight through to the memory. While a
// copy runs, the CPU port is ignored and bytes are moved one per two cycles:
// a read cycle that captures the combinational read data, then a write cycle.
module mem_copy_dma
    import mem_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_wr_en,
    input  logic [DW-1:0] cpu_dat,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_dat_wr,
    input  logic [DW-1:0] mem_dat_rd
);

    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

    dma_state_t    state_q, state_d;
    logic [AW-1:0] src_ptr_q, src_ptr_d;
    logic [AW-1:0] dst_ptr_q, dst_ptr_d;
    logic [AW-1:0] remaining_q, remaining_d;
    logic [DW-1:0] byte_buf_q, byte_buf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [AW-1:0] mem_addr_s;
    logic          mem_wr_en_s;
    logic [DW-1:0] mem_dat_wr_s;

    // Next-state, pointer and status computation for the copy sequencer.
    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        byte_buf_d  = byte_buf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != ADDR_ZERO) begin
                        src_ptr_d   = src_addr;
                        dst_ptr_d   = dst_addr;
                        remaining_d = len;
                        state_d     = RD;
                    end else begin
                        // Zero-length request still produces a done pulse.
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                byte_buf_d = mem_dat_rd;
                state_d    = WR;
            end
            WR: begin
                // Pointers wrap naturally at the address width.
                src_ptr_d   = src_ptr_q + ADDR_ONE;
                dst_ptr_d   = dst_ptr_q + ADDR_ONE;
                remaining_d = remaining_q - ADDR_ONE;
                if (remaining_q == ADDR_ONE) begin
                    state_d = DONE;
                end else begin
                    state_d = RD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status flags are registered copies of what the next state implies.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Sequencer state, pointers, captured byte and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            src_ptr_q   <= ADDR_ZERO;
            dst_ptr_q   <= ADDR_ZERO;
            remaining_q <= ADDR_ZERO;
            byte_buf_q  <= DATA_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            byte_buf_q  <= byte_buf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Memory port mux: CPU owns the port in IDLE, the copy engine otherwise.
    always_comb begin
        mem_addr_s   = cpu_addr;
        mem_wr_en_s  = 1'b0;
        mem_dat_wr_s = cpu_dat;
        case (state_q)
            IDLE: begin
                mem_addr_s   = cpu_addr;
                mem_wr_en_s  = cpu_wr_en;
                mem_dat_wr_s = cpu_dat;
            end
            RD: begin
                mem_addr_s   = src_ptr_q;
                mem_wr_en_s  = 1'b0;
                mem_dat_wr_s = byte_buf_q;
            end
            WR: begin
                mem_addr_s   = dst_ptr_q;
                mem_wr_en_s  = 1'b1;
                mem_dat_wr_s = byte_buf_q;
            end
            DONE: begin
                mem_addr_s   = dst_ptr_q;
                mem_wr_en_s  = 1'b0;
                mem_dat_wr_s = byte_buf_q;
            end
            default: begin
                mem_addr_s   = cpu_addr;
                mem_wr_en_s  = 1'b0;
                mem_dat_wr_s = cpu_dat;
            end
        endcase
    end

    // Drive the memory port; writes are blocked outright while reset is held
    // so a CPU store presented during reset cannot reach the memory.
    always_comb begin
        mem_addr   = mem_addr_s;
        mem_dat_wr = mem_dat_wr_s;
        if (reset) begin
            mem_wr_en = 1'b0;
        end else begin
            mem_wr_en = mem_wr_en_s;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule : mem_copy_dma

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma with a behavioural 256-byte memory.
module tb_mem_copy_dma;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic [7:0] cpu_addr;
    logic       cpu_wr_en;
    logic [7:0] cpu_dat;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_dat_wr;
    logic [7:0] mem_dat_rd;

    // Data memory: combinational read, clocked write.
    logic [7:0] mem [0:255];
    // Reference image of what memory should contain.
    logic [7:0] ref_mem [0:255];

    int checks;
    int failures;

    mem_copy_dma dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .cpu_addr  (cpu_addr),
        .cpu_wr_en (cpu_wr_en),
        .cpu_dat   (cpu_dat),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_dat_wr(mem_dat_wr),
        .mem_dat_rd(mem_dat_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory write port.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_dat_wr;
    end
    assign mem_dat_rd = mem[mem_addr];

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] ln;
        bit         mid;
        bit         same;
        int         exp_busy;
        int         exp_done;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr  = a;
        cpu_dat   = d;
        cpu_wr_en = 1'b1;
        @(negedge clk);
        cpu_wr_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic cmp_mem(input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                if (bad == 0)
                    $display("FAIL %s: mem[%0d] got 0x%0h expected 0x%0h", nm, i, mem[i], ref_mem[i]);
                bad++;
            end
        end
        checks++;
        if (bad != 0) failures++;
    endtask

    // Reference copy: strictly ascending, byte-by-byte, wrapping addresses.
    task automatic ref_copy(input logic [7:0] s, input logic [7:0] d, input int n);
        logic [7:0] sa, da;
        for (int k = 0; k < n; k++) begin
            sa = s + 8'(k);
            da = d + 8'(k);
            ref_mem[da] = ref_mem[sa];
        end
    endtask

    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input bit mid, input bit same, input int exp_busy,
                            input int exp_done, input string nm);
        int busy_n, done_n, done_at, wr_n;
        bit fin;
        busy_n = 0; done_n = 0; done_at = -1; wr_n = 0; fin = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = l;
        if (same) begin
            cpu_wr_en = 1'b1;
            cpu_addr  = 8'd9;
            cpu_dat   = 8'hC9;
            ref_mem[9] = 8'hC9;
        end
        @(posedge clk);
        for (int c = 0; c < 600 && !fin; c++) begin
            @(negedge clk);
            if (busy) busy_n++; else fin = 1'b1;
            if (done) begin done_n++; done_at = c; end
            if (mem_wr_en) wr_n++;
            start     = 1'b0;
            cpu_wr_en = 1'b0;
            if (mid && c == 1) begin
                start     = 1'b1;
                src_addr  = 8'd0;
                dst_addr  = 8'd200;
                len       = 8'd5;
                cpu_wr_en = 1'b1;
                cpu_addr  = 8'd8;
                cpu_dat   = 8'hEE;
            end
        end
        chk({nm, "_timeout"}, int'(fin), 1);
        chk({nm, "_busy_cycles"}, busy_n, exp_busy);
        chk({nm, "_done_count"}, done_n, 1);
        chk({nm, "_done_cycle"}, done_at, exp_done);
        chk({nm, "_writes"}, wr_n, int'(l));
        ref_copy(s, d, int'(l));
        cmp_mem({nm, "_mem"});
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; start = 1'b0; src_addr = 8'd0; dst_addr = 8'd0; len = 8'd0;
        cpu_addr = 8'd3; cpu_wr_en = 1'b1; cpu_dat = 8'h77;

        // Reset state, including a CPU store attempted while reset is held.
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr_en_forced", int'(mem_wr_en), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0; cpu_wr_en = 1'b0;

        // Fill memory with random content through the CPU pass-through.
        for (int i = 0; i < 256; i++) cpu_write(8'(i), 8'($urandom));
        cmp_mem("init_fill");

        // CPU pass-through and directed preloads.
        cpu_write(8'd7, 8'h5A);
        chk("cpu_passthru", int'(mem[7]), 8'h5A);
        cpu_write(8'd10, 8'hA1); cpu_write(8'd11, 8'hB2);
        cpu_write(8'd12, 8'hC3); cpu_write(8'd13, 8'hD4);
        cpu_write(8'd254, 8'h11); cpu_write(8'd255, 8'h22); cpu_write(8'd0, 8'h33);
        cpu_write(8'd20, 8'h01); cpu_write(8'd21, 8'h02); cpu_write(8'd22, 8'h03);

        vecs[0] = '{src: 8'd10,  dst: 8'd100, ln: 8'd4, mid: 1'b0, same: 1'b0, exp_busy: 9, exp_done: 8};
        vecs[1] = '{src: 8'd5,   dst: 8'd6,   ln: 8'd0, mid: 1'b0, same: 1'b0, exp_busy: 1, exp_done: 0};
        vecs[2] = '{src: 8'd254, dst: 8'd40,  ln: 8'd3, mid: 1'b0, same: 1'b0, exp_busy: 7, exp_done: 6};
        vecs[3] = '{src: 8'd20,  dst: 8'd21,  ln: 8'd2, mid: 1'b0, same: 1'b0, exp_busy: 5, exp_done: 4};
        vecs[4] = '{src: 8'd50,  dst: 8'd60,  ln: 8'd3, mid: 1'b1, same: 1'b0, exp_busy: 7, exp_done: 6};
        vecs[5] = '{src: 8'd9,   dst: 8'd80,  ln: 8'd1, mid: 1'b0, same: 1'b1, exp_busy: 3, exp_done: 2};

        for (int v = 0; v < 6; v++) begin
            run_copy(vecs[v].src, vecs[v].dst, vecs[v].ln, vecs[v].mid, vecs[v].same,
                     vecs[v].exp_busy, vecs[v].exp_done, $sformatf("vec%0d", v));
        end

        // Directed content checks against literal expectations.
        chk("basic_100", int'(mem[100]), 8'hA1);
        chk("basic_103", int'(mem[103]), 8'hD4);
        chk("wrap_40", int'(mem[40]), 8'h11);
        chk("wrap_42", int'(mem[42]), 8'h33);
        chk("overlap_21", int'(mem[21]), 8'h01);
        chk("overlap_22", int'(mem[22]), 8'h01);
        chk("same_cycle_cpu_9", int'(mem[9]), 8'hC9);
        chk("same_cycle_copy_80", int'(mem[80]), 8'hC9);

        // Reset during the second write of a four-byte copy.
        begin
            int c;
            cpu_write(8'd30, 8'h5C); cpu_write(8'd31, 8'h6D);
            cpu_write(8'd32, 8'h7E); cpu_write(8'd33, 8'h8F);
            @(negedge clk);
            start = 1'b1; src_addr = 8'd30; dst_addr = 8'd130; len = 8'd4;
            @(posedge clk);
            for (c = 0; c < 3; c++) begin
                @(negedge clk);
                start = 1'b0;
            end
            @(negedge clk);
            chk("abort_in_wr", int'(mem_wr_en), 1);
            reset = 1'b1;
            #1;
            chk("abort_busy", int'(busy), 0);
            chk("abort_done", int'(done), 0);
            chk("abort_wr_en", int'(mem_wr_en), 0);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
            ref_copy(8'd30, 8'd130, 1);
            cmp_mem("abort_mem");
            chk("abort_byte0", int'(mem[130]), 8'h5C);
        end
        run_copy(8'd30, 8'd140, 8'd4, 1'b0, 1'b0, 9, 8, "after_abort");

        // Randomised copies checked against the reference model.
        for (int r = 0; r < 20; r++) begin
            logic [7:0] rs, rd, rl;
            rs = 8'($urandom);
            rd = 8'($urandom);
            rl = 8'($urandom_range(0, 24));
            run_copy(rs, rd, rl, 1'b0, 1'b0, 2 * int'(rl) + 1, 2 * int'(rl), $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_copy_dma
